// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side handshakes around the shared memory port.
// The master modport is the arbiter's view; slave is the requesters/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                ifu_req_valid;
    logic                ifu_req_ready;
    logic [ADDR_W-1:0]   ifu_addr;
    logic                ifu_resp_valid;
    logic [31:0]         ifu_rdata;
    logic                ifu_err;

    logic                lsu_req_valid;
    logic                lsu_req_ready;
    logic [ADDR_W-1:0]   lsu_addr;
    logic                lsu_wen;
    logic [DATA_W-1:0]   lsu_wdata;
    logic [DATA_W/8-1:0] lsu_wmask;
    logic                lsu_resp_valid;
    logic [DATA_W-1:0]   lsu_rdata;
    logic                lsu_err;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_wen;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_wmask;
    logic                mem_resp_valid;
    logic [DATA_W-1:0]   mem_rdata;

    modport master (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_err,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_err,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU (read-only) and LSU.
// LSU has fixed priority; a timeout returns an error response if memory never answers.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic              owner;          // 0 = IFU, 1 = LSU
    logic [CNT_W-1:0]  to_cnt;
    logic              ifu_acc, lsu_acc, resp_hit, timed_out;
    logic [5:0]        word_lsb;
    logic [31:0]       ifu_word;

    assign bus.lsu_req_ready = (state == IDLE);
    assign bus.ifu_req_ready = (state == IDLE) && !bus.lsu_req_valid;

    always_comb begin
        state_nxt = state;
        lsu_acc   = bus.lsu_req_valid && bus.lsu_req_ready;
        ifu_acc   = bus.ifu_req_valid && bus.ifu_req_ready;
        // Responses only count in WAIT; a same-cycle response beats the timeout.
        resp_hit  = (state == WAIT) && bus.mem_resp_valid;
        timed_out = ((state == REQ) || (state == WAIT)) && (to_cnt == TO_MAX) && !resp_hit;
        case (state)
            IDLE: if (lsu_acc || ifu_acc) state_nxt = REQ;
            REQ: begin
                if (timed_out)              state_nxt = RESP;
                else if (bus.mem_req_ready) state_nxt = WAIT;
            end
            WAIT: if (resp_hit || timed_out) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Instruction word is picked by address bit 2 of the latched fetch address.
    always_comb begin
        word_lsb = (DATA_W >= 64 && bus.mem_addr[2]) ? 6'd32 : 6'd0;
        ifu_word = bus.mem_rdata[word_lsb +: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            owner              <= 1'b0;
            to_cnt             <= '0;
            bus.mem_req_valid  <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_wen        <= 1'b0;
            bus.mem_wdata      <= '0;
            bus.mem_wmask      <= '0;
            bus.ifu_resp_valid <= 1'b0;
            bus.ifu_err        <= 1'b0;
            bus.ifu_rdata      <= '0;
            bus.lsu_resp_valid <= 1'b0;
            bus.lsu_err        <= 1'b0;
            bus.lsu_rdata      <= '0;
        end else begin
            state              <= state_nxt;
            bus.ifu_resp_valid <= 1'b0;
            bus.lsu_resp_valid <= 1'b0;
            if ((state == REQ) || (state == WAIT))
                to_cnt <= to_cnt + 1'b1;

            if (lsu_acc) begin
                owner             <= 1'b1;
                to_cnt            <= '0;
                bus.mem_req_valid <= 1'b1;
                bus.mem_addr      <= bus.lsu_addr;
                bus.mem_wen       <= bus.lsu_wen;
                bus.mem_wdata     <= bus.lsu_wdata;
                bus.mem_wmask     <= bus.lsu_wen ? bus.lsu_wmask : '0;
            end else if (ifu_acc) begin
                owner             <= 1'b0;
                to_cnt            <= '0;
                bus.mem_req_valid <= 1'b1;
                bus.mem_addr      <= bus.ifu_addr;
                bus.mem_wen       <= 1'b0;
                bus.mem_wdata     <= '0;
                bus.mem_wmask     <= '0;
            end

            if ((state == REQ) && (timed_out || bus.mem_req_ready))
                bus.mem_req_valid <= 1'b0;

            if (resp_hit || timed_out) begin
                if (owner) begin
                    bus.lsu_resp_valid <= 1'b1;
                    bus.lsu_err        <= timed_out;
                    bus.lsu_rdata      <= (resp_hit && !bus.mem_wen) ? bus.mem_rdata : '0;
                end else begin
                    bus.ifu_resp_valid <= 1'b1;
                    bus.ifu_err        <= timed_out;
                    bus.ifu_rdata      <= resp_hit ? ifu_word : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: expected responses are queued at request time
// and popped by a negedge monitor; each scenario task also checks timing inline.
module tb_mem_port_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct packed {
        logic          lsu;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Response monitor: every response pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        if (!rst && (bus.ifu_resp_valid || bus.lsu_resp_valid)) begin
            got.lsu   = bus.lsu_resp_valid;
            got.err   = bus.lsu_resp_valid ? bus.lsu_err : bus.ifu_err;
            got.rdata = bus.lsu_resp_valid ? bus.lsu_rdata : {32'b0, bus.ifu_rdata};
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_resp: got lsu=%0b err=%0b rdata=%h, expected none",
                         got.lsu, got.err, got.rdata);
            end else begin
                e = sb.pop_front();
                if (got !== e || (bus.ifu_resp_valid && bus.lsu_resp_valid)) begin
                    n_fail++;
                    $display("FAIL sb_resp: got lsu=%0b err=%0b rdata=%h (both=%0b), expected lsu=%0b err=%0b rdata=%h",
                             got.lsu, got.err, got.rdata, bus.ifu_resp_valid && bus.lsu_resp_valid,
                             e.lsu, e.err, e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [AW+1+DW+DW/8+1+32+1+1+DW+1+1-1:0] outs;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        outs = {bus.mem_addr, bus.mem_wen, bus.mem_wdata, bus.mem_wmask, bus.mem_req_valid,
                bus.ifu_rdata, bus.ifu_resp_valid, bus.ifu_err,
                bus.lsu_rdata, bus.lsu_resp_valid, bus.lsu_err};
        n_tests++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0", outs);
        end
        n_tests++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_ready: got %b, expected 11", {bus.ifu_req_ready, bus.lsu_req_ready});
        end
    endtask

    task automatic test_ifu_fetch();
        bus.ifu_addr      = 64'h8000_0004;
        bus.ifu_req_valid = 1'b1;
        sb.push_back(exp_t'{lsu: 1'b0, err: 1'b0, rdata: 64'h0000_0013});
        tick();                                   // accept edge
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        n_tests++;
        if ({bus.mem_req_valid, bus.mem_wen, bus.mem_wmask} !== {1'b1, 1'b0, 8'h00} ||
            bus.mem_addr !== 64'h8000_0004) begin
            n_fail++;
            $display("FAIL ifu_req: got valid=%0b wen=%0b wmask=%h addr=%h, expected 1 0 00 80000004",
                     bus.mem_req_valid, bus.mem_wen, bus.mem_wmask, bus.mem_addr);
        end
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h0000_0013_0010_0093;
        tick();
        bus.mem_resp_valid = 1'b0;
        n_tests++;
        if ({bus.ifu_resp_valid, bus.ifu_err, bus.ifu_rdata} !== {1'b1, 1'b0, 32'h0000_0013}) begin
            n_fail++;
            $display("FAIL ifu_resp_latency: got valid=%0b err=%0b rdata=%h, expected 1 0 00000013",
                     bus.ifu_resp_valid, bus.ifu_err, bus.ifu_rdata);
        end
        tick();
        n_tests++;
        if (bus.ifu_resp_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL ifu_resp_pulse: got valid=%0b pending=%0d, expected 0 0",
                     bus.ifu_resp_valid, sb.size());
        end
    endtask

    task automatic test_simultaneous();
        bus.ifu_addr      = 64'h8000_0000;
        bus.ifu_req_valid = 1'b1;
        bus.lsu_addr      = 64'h8000_1000;
        bus.lsu_wen       = 1'b1;
        bus.lsu_wdata     = 64'h1122_3344_5566_7788;
        bus.lsu_wmask     = 8'h0F;
        bus.lsu_req_valid = 1'b1;
        #1;
        n_tests++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL sim_priority_ready: got ifu/lsu=%b, expected 01",
                     {bus.ifu_req_ready, bus.lsu_req_ready});
        end
        sb.push_back(exp_t'{lsu: 1'b1, err: 1'b0, rdata: 64'h0});
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        n_tests++;
        if (bus.mem_addr !== 64'h8000_1000 || bus.mem_wen !== 1'b1 ||
            bus.mem_wmask !== 8'h0F || bus.mem_wdata !== 64'h1122_3344_5566_7788) begin
            n_fail++;
            $display("FAIL sim_lsu_store_req: got addr=%h wen=%0b wmask=%h wdata=%h, expected 80001000 1 0f 1122334455667788",
                     bus.mem_addr, bus.mem_wen, bus.mem_wmask, bus.mem_wdata);
        end
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        bus.mem_resp_valid = 1'b0;
        n_tests++;
        if ({bus.lsu_resp_valid, bus.lsu_err} !== 2'b10 || bus.lsu_rdata !== '0 ||
            bus.ifu_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_lsu_resp: got valid=%0b err=%0b rdata=%h ifu_valid=%0b, expected 1 0 0 0",
                     bus.lsu_resp_valid, bus.lsu_err, bus.lsu_rdata, bus.ifu_resp_valid);
        end
        sb.push_back(exp_t'{lsu: 1'b0, err: 1'b0, rdata: 64'hBBBB_BBBB});
        tick();                                   // back in IDLE, IFU still asserting
        n_tests++;
        if (bus.ifu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_ifu_ready_after: got %0b, expected 1", bus.ifu_req_ready);
        end
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        n_tests++;
        if (bus.mem_addr !== 64'h8000_0000 || bus.mem_wen !== 1'b0 || bus.mem_wmask !== 8'h00) begin
            n_fail++;
            $display("FAIL sim_ifu_req: got addr=%h wen=%0b wmask=%h, expected 80000000 0 00",
                     bus.mem_addr, bus.mem_wen, bus.mem_wmask);
        end
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'hAAAA_AAAA_BBBB_BBBB;
        tick();
        bus.mem_resp_valid = 1'b0;
        tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sim_pending: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_backpressure();
        bit stable = 1'b1;
        bus.lsu_addr      = 64'h8000_2008;
        bus.lsu_wen       = 1'b0;
        bus.lsu_wdata     = 64'h5555_6666_7777_8888;
        bus.lsu_wmask     = 8'hFF;
        bus.lsu_req_valid = 1'b1;
        sb.push_back(exp_t'{lsu: 1'b1, err: 1'b0, rdata: 64'h0123_4567_89AB_CDEF});
        tick();
        bus.lsu_req_valid = 1'b0;
        bus.lsu_addr      = 64'hFFFF_0000;        // scramble inputs; outputs must stay latched
        bus.lsu_wdata     = 64'h0;
        for (int i = 0; i < 5; i++) begin
            if (bus.mem_req_valid !== 1'b1 || bus.mem_addr !== 64'h8000_2008 ||
                bus.mem_wdata !== 64'h5555_6666_7777_8888 || bus.mem_wmask !== 8'h00)
                stable = 1'b0;
            tick();
        end
        n_tests++;
        if (!stable || bus.mem_req_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got valid=%0b addr=%h wdata=%h wmask=%h, expected 1 80002008 5555666677778888 00",
                     bus.mem_req_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
        end
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        n_tests++;
        if (bus.mem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drop_valid: got %0b, expected 0", bus.mem_req_valid);
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h0123_4567_89AB_CDEF;
        tick();
        bus.mem_resp_valid = 1'b0;
        tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_pending: got %0d pending, expected 0", sb.size());
        end
    endtask

    task automatic test_timeout();
        bit ok = 1'b1;
        bus.lsu_addr      = 64'h8000_3000;
        bus.lsu_wen       = 1'b0;
        bus.lsu_req_valid = 1'b1;
        sb.push_back(exp_t'{lsu: 1'b1, err: 1'b1, rdata: 64'h0});
        tick();                                   // enter REQ
        bus.lsu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        for (int k = 1; k <= TO; k++) begin
            tick();
            bus.mem_req_ready = 1'b0;
            if (k < TO && bus.lsu_resp_valid !== 1'b0) ok = 1'b0;
        end
        n_tests++;
        if (!ok || {bus.lsu_resp_valid, bus.lsu_err} !== 2'b11 || bus.lsu_rdata !== '0) begin
            n_fail++;
            $display("FAIL timeout_resp: got early_ok=%0b valid=%0b err=%0b rdata=%h, expected 1 1 1 0",
                     ok, bus.lsu_resp_valid, bus.lsu_err, bus.lsu_rdata);
        end
        tick();
        tick();
        bus.mem_resp_valid = 1'b1;                // late response, must be dropped
        bus.mem_rdata      = 64'h1111_2222_3333_4444;
        tick();
        bus.mem_resp_valid = 1'b0;
        tick();
        n_tests++;
        if (bus.lsu_resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_late_resp: got valid=%0b req_valid=%0b pending=%0d, expected 0 0 0",
                     bus.lsu_resp_valid, bus.mem_req_valid, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        bus.ifu_addr      = 64'h8000_0008;
        bus.ifu_req_valid = 1'b1;
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();                                   // now in WAIT
        bus.mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.ifu_resp_valid, bus.ifu_rdata,
             bus.lsu_resp_valid} !== '0 || {bus.ifu_req_ready, bus.lsu_req_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got valid=%0b addr=%h ready=%b, expected 0 0 11",
                     bus.mem_req_valid, bus.mem_addr, {bus.ifu_req_ready, bus.lsu_req_ready});
        end
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'h9999_9999_9999_9999;
        tick();
        bus.mem_resp_valid = 1'b0;
        tick();
        n_tests++;
        if ({bus.ifu_resp_valid, bus.lsu_resp_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_mid_stale_resp: got %b, expected 00",
                     {bus.ifu_resp_valid, bus.lsu_resp_valid});
        end
        bus.ifu_addr      = 64'h8000_000C;
        bus.ifu_req_valid = 1'b1;
        sb.push_back(exp_t'{lsu: 1'b0, err: 1'b0, rdata: 64'hCAFE_F00D});
        tick();
        bus.ifu_req_valid = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = 64'hCAFE_F00D_0000_1111;
        tick();
        bus.mem_resp_valid = 1'b0;
        n_tests++;
        if ({bus.ifu_resp_valid, bus.ifu_err, bus.ifu_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL rst_mid_next_fetch: got valid=%0b err=%0b rdata=%h, expected 1 0 cafef00d",
                     bus.ifu_resp_valid, bus.ifu_err, bus.ifu_rdata);
        end
        tick();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL rst_mid_pending: got %0d pending, expected 0", sb.size());
        end
    endtask

    initial begin
        bus.ifu_req_valid  = 1'b0;
        bus.ifu_addr       = '0;
        bus.lsu_req_valid  = 1'b0;
        bus.lsu_addr       = '0;
        bus.lsu_wen        = 1'b0;
        bus.lsu_wdata      = '0;
        bus.lsu_wmask      = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = '0;
        test_reset();
        test_ifu_fetch();
        test_simultaneous();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
